// File: rtl/taxi_reset_seq.sv
// Reset sequencer: filters PLL/MMCM lock, releases N resets in order, re-arms on lock loss or SW request.
// Optional MMCM reset watchdog is enabled by defining TAXI_RESET_SEQ_WDT_EN.
module taxi_reset_seq #(
    parameter int unsigned N            = 4,
    parameter int unsigned LOCK_W       = 1,
    parameter int unsigned SYNC_N       = 3,
    parameter int unsigned LOCK_FILT    = 256,
    parameter int unsigned STAGE_DLY    = 1024,
    parameter int unsigned WDT_CYC      = 1000000,
    parameter int unsigned RELOCK_PULSE = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [LOCK_W-1:0] lock_in,
    input  logic              sw_rst_req,
    output logic [N-1:0]      rst_out,
    output logic              done,
    output logic [7:0]        lock_loss_cnt,
    output logic              mmcm_rst
);

    localparam int unsigned MAX_DLY = (LOCK_FILT > STAGE_DLY) ? LOCK_FILT : STAGE_DLY;
    localparam int unsigned CW      = $clog2(MAX_DLY + 1);
    localparam int unsigned IW      = (N > 1) ? $clog2(N) : 1;

    localparam logic [CW-1:0] FILT_LAST  = CW'(LOCK_FILT - 1);
    localparam logic [CW-1:0] STAGE_LAST = CW'(STAGE_DLY - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(N - 1);

    typedef enum logic [1:0] {
        WAIT_LOCK,
        FILTER,
        RELEASE,
        RUN
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [N-1:0]      rst_out_q, rst_out_d;
    logic              done_q, done_d;
    logic [7:0]        loss_q, loss_d;
    logic [LOCK_W-1:0] sync_q [SYNC_N];

    logic all_lock;
    logic lock_lost;
    logic abort;
    logic release_go;
    logic hold;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < SYNC_N; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= lock_in;
            for (int unsigned i = 1; i < SYNC_N; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign all_lock   = &sync_q[SYNC_N-1];
    assign lock_lost  = !all_lock && (state_q == RELEASE || state_q == RUN);
    assign abort      = sw_rst_req || lock_lost;
    assign release_go = (state_q == FILTER) && all_lock && !sw_rst_req && (cnt_q == FILT_LAST);

`ifdef TAXI_RESET_SEQ_WDT_EN
    localparam int unsigned WW = $clog2(WDT_CYC + 1);
    localparam int unsigned PW = $clog2(RELOCK_PULSE + 1);

    logic [WW-1:0] wdt_q, wdt_d;
    logic [PW-1:0] pls_q, pls_d;
    logic          mmcm_q, mmcm_d;

    always_comb begin
        wdt_d  = wdt_q;
        pls_d  = pls_q;
        mmcm_d = mmcm_q;
        if (mmcm_q) begin
            if (pls_q == PW'(RELOCK_PULSE - 1)) begin
                mmcm_d = 1'b0;
                // last pulse edge also counts as the first tick of the next watchdog period
                wdt_d  = sw_rst_req ? '0 : WW'(1);
            end else begin
                pls_d = pls_q + PW'(1);
            end
        end else if (sw_rst_req || release_go || state_q == RELEASE || state_q == RUN) begin
            wdt_d = '0;
        end else if (wdt_q == WW'(WDT_CYC - 1)) begin
            mmcm_d = 1'b1;
            pls_d  = '0;
            wdt_d  = '0;
        end else begin
            wdt_d = wdt_q + WW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdt_q  <= '0;
            pls_q  <= '0;
            mmcm_q <= 1'b0;
        end else begin
            wdt_q  <= wdt_d;
            pls_q  <= pls_d;
            mmcm_q <= mmcm_d;
        end
    end

    assign hold     = mmcm_d;
    assign mmcm_rst = mmcm_q;
`else
    assign hold     = 1'b0;
    assign mmcm_rst = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        rst_out_d = rst_out_q;
        done_d    = done_q;
        loss_d    = loss_q;

        if (lock_lost && loss_q != 8'hFF) begin
            loss_d = loss_q + 8'd1;
        end

        if (abort) begin
            state_d   = WAIT_LOCK;
            cnt_d     = '0;
            idx_d     = '0;
            rst_out_d = '1;
            done_d    = 1'b0;
        end else begin
            case (state_q)
                WAIT_LOCK: begin
                    if (all_lock) begin
                        state_d = FILTER;
                        cnt_d   = '0;
                    end
                end
                FILTER: begin
                    if (!all_lock) begin
                        state_d = WAIT_LOCK;
                        cnt_d   = '0;
                    end else if (release_go) begin
                        cnt_d        = '0;
                        rst_out_d[0] = 1'b0;
                        if (N == 1) begin
                            state_d = RUN;
                            done_d  = 1'b1;
                        end else begin
                            state_d = RELEASE;
                            idx_d   = IW'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                RELEASE: begin
                    if (cnt_q == STAGE_LAST) begin
                        cnt_d            = '0;
                        rst_out_d[idx_q] = 1'b0;
                        idx_d            = idx_q + IW'(1);
                        if (idx_q == IDX_LAST) begin
                            state_d = RUN;
                            done_d  = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                RUN: begin
                end
            endcase
        end

        if (hold) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= WAIT_LOCK;
            cnt_q     <= '0;
            idx_q     <= '0;
            rst_out_q <= '1;
            done_q    <= 1'b0;
            loss_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            rst_out_q <= rst_out_d;
            done_q    <= done_d;
            loss_q    <= loss_d;
        end
    end

    assign rst_out       = rst_out_q;
    assign done          = done_q;
    assign lock_loss_cnt = loss_q;

endmodule

// File: tb/tb_taxi_reset_seq.sv
// Scoreboard bench for taxi_reset_seq: an elapsed-time reference model pushes expected outputs,
// a monitor pops and compares. Define TAXI_RESET_SEQ_WDT_EN to exercise the watchdog instead.
module tb_taxi_reset_seq;

    localparam int N      = 3;
    localparam int LOCK_W = 1;
    localparam int SYNC_N = 2;
    localparam int LF     = 8;
    localparam int SD     = 4;
    localparam int WDT    = 50;
    localparam int RP     = 16;

    typedef struct packed {
        logic [N-1:0] ro;
        logic         dn;
        logic [7:0]   ls;
        logic         mm;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [LOCK_W-1:0] lock_in;
    logic              sw_rst_req;
    logic [N-1:0]      rst_out;
    logic              done;
    logic [7:0]        lock_loss_cnt;
    logic              mmcm_rst;

    always #5 clk = ~clk;

    taxi_reset_seq #(
        .N(N), .LOCK_W(LOCK_W), .SYNC_N(SYNC_N), .LOCK_FILT(LF),
        .STAGE_DLY(SD), .WDT_CYC(WDT), .RELOCK_PULSE(RP)
    ) dut (
        .clk(clk), .rst(rst), .lock_in(lock_in), .sw_rst_req(sw_rst_req),
        .rst_out(rst_out), .done(done), .lock_loss_cnt(lock_loss_cnt), .mmcm_rst(mmcm_rst)
    );

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    int   e     = -1;   // edges since leaving WAIT_LOCK; -1 = waiting for lock
    int   mloss = 0;
    int   wcyc  = -1;   // edges since reset release
    logic al;
    logic hq[$];
    exp_t mx, px;
    exp_t sbq[$];

    // Reference model: stage k is released once lock has been continuously good for LF+k*SD edges.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            e = -1; mloss = 0; wcyc = -1;
            hq.delete();
            for (int i = 0; i < SYNC_N; i++) hq.push_back(1'b0);
        end else begin
            cyc++; wcyc++;
            al = hq.pop_front();
            hq.push_back(&lock_in);
            if (e < 0) begin
                if (!sw_rst_req && al) e = 0;
            end else if (e < LF) begin
                if (sw_rst_req || !al) e = -1; else e++;
            end else begin
                if (!al) begin
                    if (mloss < 255) mloss++;
                    e = -1;
                end else if (sw_rst_req) e = -1;
                else if (e < 1000000) e++;
            end
        end
        for (int k = 0; k < N; k++) mx.ro[k] = (e >= LF + k * SD) ? 1'b0 : 1'b1;
        mx.dn = (e >= LF + (N - 1) * SD);
        mx.ls = 8'(mloss);
`ifdef TAXI_RESET_SEQ_WDT_EN
        mx.mm = (wcyc >= 0) && ((wcyc % (WDT + RP - 1)) >= WDT - 1)
                            && ((wcyc % (WDT + RP - 1)) <= WDT + RP - 2);
`else
        mx.mm = 1'b0;
`endif
        sbq.push_back(mx);
    end

    always begin
        @(posedge clk or posedge rst);
        #1;
        while (sbq.size() > 0) begin
            px = sbq.pop_front();
            n_cmp++;
            if ({rst_out, done, lock_loss_cnt, mmcm_rst} !== px) begin
                n_bad++;
                if (n_bad <= 20)
                    $display("FAIL scoreboard cyc=%0d: got rst_out=%b done=%b loss=%0d mmcm=%b, expected rst_out=%b done=%b loss=%0d mmcm=%b",
                             cyc, rst_out, done, lock_loss_cnt, mmcm_rst, px.ro, px.dn, px.ls, px.mm);
            end
        end
    end

    task automatic check(input string nm, input int act, input int exp_v);
        n_cmp++;
        if (act != exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
        end
    endtask

    // which: 0..N-1 rst_out[which] low, N done high, N+1 mmcm_rst high, N+2 mmcm_rst low
    task automatic wait_for(input int which, output int at);
        logic hit;
        at = -1;
        for (int i = 0; i < 200; i++) begin
            if (which < N)          hit = (rst_out[which] == 1'b0);
            else if (which == N)    hit = (done == 1'b1);
            else if (which == N+1)  hit = (mmcm_rst == 1'b1);
            else                    hit = (mmcm_rst == 1'b0);
            if (hit) begin
                at = cyc;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic pulse_sw();
        sw_rst_req = 1'b1;
        @(negedge clk);
        sw_rst_req = 1'b0;
    endtask

    task automatic relock_timing(input string tag);
        int c0, a;
        c0 = cyc;
        lock_in = 1'b1;
        wait_for(0, a); check({tag, " rst_out[0] release"}, a - c0, LF + SYNC_N + 1);
        wait_for(1, a); check({tag, " rst_out[1] release"}, a - c0, LF + SYNC_N + 1 + SD);
        wait_for(2, a); check({tag, " rst_out[2] release"}, a - c0, LF + SYNC_N + 1 + 2 * SD);
        wait_for(N, a); check({tag, " done rise"},          a - c0, LF + SYNC_N + 1 + 2 * SD);
    endtask

    initial begin
        int a, c0, cr, dur;
        rst = 1'b0; lock_in = '0; sw_rst_req = 1'b0;
        #2 rst = 1'b1;
        #1 check("reset rst_out", int'(rst_out), 7);
        check("reset done", int'(done), 0);
        repeat (3) @(negedge clk);
        cr = cyc;
        rst = 1'b0;
`ifdef TAXI_RESET_SEQ_WDT_EN
        wait_for(N+1, a); check("wdt first rise", a - (cr + 1), WDT - 1);
        wait_for(N+2, a); check("wdt first fall", a - (cr + 1), WDT + RP - 1);
        wait_for(N+1, a); check("wdt second rise", a - (cr + 1), 2 * (WDT + RP - 1) - RP);
        repeat (5) @(negedge clk);
        pulse_sw();
        check("wdt pulse holds through sw", int'(mmcm_rst), 1);
        wait_for(N+2, a); check("wdt second fall", a - (cr + 1), 2 * (WDT + RP - 1));
        check("wdt rst_out held", int'(rst_out), 7);
`else
        repeat (4) @(negedge clk);
        relock_timing("basic");
        repeat (3) @(negedge clk);
        check("run loss", int'(lock_loss_cnt), 0);

        pulse_sw();
        check("sw abort rst_out", int'(rst_out), 7);
        check("sw abort loss", int'(lock_loss_cnt), 0);
        wait_for(N, a);
        check("refilter after sw done", int'(done), 1);

        lock_in = 1'b0;
        repeat (5) @(negedge clk);
        check("lock loss rst_out", int'(rst_out), 7);
        check("lock loss done", int'(done), 0);
        check("lock loss count", int'(lock_loss_cnt), 1);
        relock_timing("relock");

        lock_in = 1'b0;
        repeat (2) @(negedge clk);
        pulse_sw();
        check("simultaneous loss+sw count", int'(lock_loss_cnt), 2);
        check("simultaneous rst_out", int'(rst_out), 7);
        repeat (3) @(negedge clk);

        lock_in = 1'b1;
        wait_for(1, a);
        check("mid-release rst_out", int'(rst_out), 4);
        #2 rst = 1'b1;
        #1 check("async reset rst_out", int'(rst_out), 7);
        check("async reset loss", int'(lock_loss_cnt), 0);
        lock_in = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        c0 = cyc;
        lock_in = 1'b1;
        repeat (6) @(negedge clk);
        lock_in = 1'b0;
        @(negedge clk);
        lock_in = 1'b1;
        wait_for(0, a);
        check("glitch restart release", a - c0, 7 + LF + SYNC_N + 1);
        check("glitch loss", int'(lock_loss_cnt), 0);

        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 3) != 0) begin
                lock_in = 1'b1;
                dur = int'($urandom_range(1, 40));
            end else begin
                lock_in = 1'b0;
                dur = int'($urandom_range(1, 6));
            end
            for (int j = 0; j < dur; j++) begin
                sw_rst_req = ($urandom_range(0, 47) == 0);
                @(negedge clk);
            end
            sw_rst_req = 1'b0;
        end

        for (int i = 0; i < 300; i++) begin
            lock_in = 1'b1;
            repeat (22) @(negedge clk);
            lock_in = 1'b0;
            repeat (4) @(negedge clk);
        end
        check("loss saturation", int'(lock_loss_cnt), 255);
        check("mmcm_rst idle", int'(mmcm_rst), 0);
`endif
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
